// File: rtl/fpc_rc_tracker_pkg.sv
// Shared constants and types for the from-PC read-completion tracker.
package fpc_rc_tracker_pkg;

    localparam int BEATS_PER_REQ         = 64;
    localparam int RR_ADDR_LSB           = 9;
    localparam int DEFAULT_NBITS_TAG_LOW = 3;
    localparam int TAG_WIDTH             = 8;
    localparam int RC_INDEX_WIDTH        = 6;
    localparam int COUNT_WIDTH           = 7;

    // Tag layout: upper TAG_WIDTH-NBITS_TAG_LOW bits select the FIFO, lower bits are tag_low.
    typedef enum logic [1:0] {
        BEAT_NONE,
        BEAT_LEGAL,
        BEAT_ILLEGAL
    } beat_kind_t;

endpackage

// File: rtl/fpc_rc_tracker_if.sv
// Request-issue and completion signals between the read-request mux, RX demux and tracker.
interface fpc_rc_tracker_if #(
    parameter int NBITS_TAG_LOW = 3
);
    logic                     issue_ready;
    logic [NBITS_TAG_LOW-1:0] issue_tag_low;
    logic                     issue;
    logic                     rc_valid;
    logic [7:0]               rc_tag;
    logic [5:0]               rc_index;
    logic                     done_valid;
    logic [NBITS_TAG_LOW-1:0] done_tag_low;
    logic [NBITS_TAG_LOW:0]   outstanding;
    logic                     error;

    modport master (
        input  issue_ready, issue_tag_low, done_valid, done_tag_low, outstanding, error,
        output issue, rc_valid, rc_tag, rc_index
    );

    modport slave (
        input  issue, rc_valid, rc_tag, rc_index,
        output issue_ready, issue_tag_low, done_valid, done_tag_low, outstanding, error
    );
endinterface

// File: rtl/fpc_rc_count_table.sv
// Per-slot beat counters; each slot reports full once a whole request has arrived.
module fpc_rc_count_table
    import fpc_rc_tracker_pkg::*;
#(
    parameter int NBITS_TAG_LOW = DEFAULT_NBITS_TAG_LOW
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            inc_en,
    input  logic [NBITS_TAG_LOW-1:0]                        inc_slot,
    input  logic                                            clr_en,
    input  logic [NBITS_TAG_LOW-1:0]                        clr_slot,
    output logic [(1<<NBITS_TAG_LOW)-1:0][COUNT_WIDTH-1:0]  count,
    output logic [(1<<NBITS_TAG_LOW)-1:0]                   full
);
    localparam int SLOTS = 1 << NBITS_TAG_LOW;

    // Clear has priority; a beat to a full slot is never legal, so the two never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (clr_en && clr_slot == NBITS_TAG_LOW'(i)) begin
                    count[i] <= '0;
                end else if (inc_en && inc_slot == NBITS_TAG_LOW'(i)) begin
                    count[i] <= count[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        full = '0;
        for (int i = 0; i < SLOTS; i++) begin
            full[i] = (count[i] == COUNT_WIDTH'(BEATS_PER_REQ));
        end
    end

endmodule

// File: rtl/fpc_rc_tracker.sv
// Hands out tag_low values for 512 B reads, counts completion beats and retires tags in issue order.
module fpc_rc_tracker
    import fpc_rc_tracker_pkg::*;
#(
    parameter int FIFO_NUMBER     = 0,
    parameter int NBITS_TAG_LOW   = DEFAULT_NBITS_TAG_LOW,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic             clock,
    input logic             reset,
    fpc_rc_tracker_if.slave bus
);
    localparam int PTR_W  = NBITS_TAG_LOW + 1;
    localparam int SLOTS  = 1 << NBITS_TAG_LOW;
    localparam int FIFO_W = TAG_WIDTH - NBITS_TAG_LOW;

    logic [PTR_W-1:0]                  issue_ptr;
    logic [PTR_W-1:0]                  retire_ptr;
    logic [PTR_W-1:0]                  outstanding;
    logic [SLOTS-1:0][COUNT_WIDTH-1:0] count;
    logic [SLOTS-1:0]                  full;
    logic [NBITS_TAG_LOW-1:0]          retire_slot;
    logic [NBITS_TAG_LOW-1:0]          beat_slot;
    logic [NBITS_TAG_LOW-1:0]          beat_age;
    logic                              retire_now;
    logic                              issue_ok;
    logic                              beat_mine;
    beat_kind_t                        beat_kind;

    assign outstanding       = issue_ptr - retire_ptr;
    assign bus.outstanding   = outstanding;
    assign bus.issue_ready   = (outstanding < PTR_W'(MAX_OUTSTANDING));
    assign bus.issue_tag_low = issue_ptr[NBITS_TAG_LOW-1:0];

    assign issue_ok    = bus.issue && bus.issue_ready;
    assign retire_slot = retire_ptr[NBITS_TAG_LOW-1:0];
    assign retire_now  = (outstanding != '0) && full[retire_slot];

    assign beat_slot = bus.rc_tag[NBITS_TAG_LOW-1:0];
    assign beat_age  = beat_slot - retire_slot;
    assign beat_mine = bus.rc_valid &&
                       (bus.rc_tag[TAG_WIDTH-1:NBITS_TAG_LOW] == FIFO_W'(FIFO_NUMBER));

    // A beat is legal only for an in-flight slot that is not yet full and only in address order.
    always_comb begin
        beat_kind = BEAT_NONE;
        if (beat_mine) begin
            if (({1'b0, beat_age} < outstanding) && !full[beat_slot] &&
                (bus.rc_index == count[beat_slot][RC_INDEX_WIDTH-1:0])) begin
                beat_kind = BEAT_LEGAL;
            end else begin
                beat_kind = BEAT_ILLEGAL;
            end
        end
    end

    fpc_rc_count_table #(
        .NBITS_TAG_LOW (NBITS_TAG_LOW)
    ) u_count_table (
        .clock    (clock),
        .reset    (reset),
        .inc_en   (beat_kind == BEAT_LEGAL),
        .inc_slot (beat_slot),
        .clr_en   (retire_now),
        .clr_slot (retire_slot),
        .count    (count),
        .full     (full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_ptr        <= '0;
            retire_ptr       <= '0;
            bus.done_valid   <= 1'b0;
            bus.done_tag_low <= '0;
            bus.error        <= 1'b0;
        end else begin
            if (issue_ok) begin
                issue_ptr <= issue_ptr + PTR_W'(1);
            end
            bus.done_valid <= retire_now;
            if (retire_now) begin
                bus.done_tag_low <= retire_slot;
                retire_ptr       <= retire_ptr + PTR_W'(1);
            end
            if ((bus.issue && !bus.issue_ready) || beat_kind == BEAT_ILLEGAL) begin
                bus.error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fpc_rc_tracker.md
Name: fpc_rc_tracker

Overview:
Per-FIFO read-completion tracker for the from-PC path. It is the responder-side counterpart of the read-request issue path. It hands out tag_low values for 512-byte read requests and counts returning 64-bit completion beats per tag. Tags are retired strictly in issue order, and each retirement is signalled to the from-PC FIFO so the block can be committed. One instance per enabled from-PC FIFO sits between the read-request mux and the completion demux from the RX decoder.

Parameters:
FIFO_NUMBER, 0, value matched against rc_tag[7:NBITS_TAG_LOW] to select this FIFO's completions
NBITS_TAG_LOW, 3, width of the per-FIFO tag index; the tag table has 2**NBITS_TAG_LOW entries
MAX_OUTSTANDING, 8, maximum number of in-flight requests; must be between 1 and 2**NBITS_TAG_LOW inclusive
BEATS_PER_REQ, 64, qwords per request (512 B); fixed by the 9-bit request address alignment

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
issue_ready  output  1  a tag is available for a new read request
issue_tag_low  output  NBITS_TAG_LOW  tag_low to use for the next request
issue  input  1  pulse: a read request using issue_tag_low was accepted by the mux
rc_valid  input  1  completion data beat valid
rc_tag  input  8  completion tag
rc_index  input  6  qword index of the beat within its 512 B request
done_valid  output  1  one-cycle pulse: the oldest request is fully received
done_tag_low  output  NBITS_TAG_LOW  tag_low of the retired request
outstanding  output  NBITS_TAG_LOW+1  number of requests in flight
error  output  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous): issue_ptr=0, retire_ptr=0, all per-tag counts=0, done_valid=0, done_tag_low=0, error=0.
- Pointers issue_ptr and retire_ptr are each NBITS_TAG_LOW+1 bits wide and wrap modulo 2**(NBITS_TAG_LOW+1).
- outstanding = issue_ptr - retire_ptr, modulo arithmetic at the same width.
- issue_ready = (outstanding < MAX_OUTSTANDING); combinational from registers.
- issue_tag_low = issue_ptr[NBITS_TAG_LOW-1:0].
- issue while issue_ready=1: issue_ptr increments at the next edge.
- issue while issue_ready=0: ignored, and error is set.
- A beat belongs to this FIFO when rc_valid=1 and rc_tag[7:NBITS_TAG_LOW]==FIFO_NUMBER.
- A matching beat to slot s is legal only when all of the following hold:
  - s is in flight, i.e. (s - retire_ptr) mod 2**NBITS_TAG_LOW < outstanding;
  - count[s] < BEATS_PER_REQ;
  - rc_index == count[s][5:0]. Completions for one request arrive in address order.
- Legal beat: count[s] increments at the next edge.
- Illegal beat: the count is unchanged and error is set (sticky until reset).
- Retire condition (combinational): outstanding != 0 and count[retire_ptr low] == BEATS_PER_REQ.
- When the retire condition holds:
  - done_valid is registered high for exactly one cycle;
  - done_tag_low = retire_ptr low;
  - count for that slot clears to 0;
  - retire_ptr increments.
- Retire latency: the 64th beat is sampled at edge N, the count reads 64 after N, and done_valid is high in the cycle after edge N+1.
- Throughput: at most one retire per cycle, and one beat per cycle.
- Back-to-back complete tags retire on consecutive cycles.
- A later tag that completes first waits until all older tags have retired (in-order rule).
- Simultaneous issue and retire: both take effect. outstanding is unchanged, and issue_ready is evaluated from the pre-edge value.
- Issue and retire cannot target the same slot. The slots coincide only when outstanding is 0 (no retire) or equal to 2**NBITS_TAG_LOW (no issue).
- Simultaneous retire and a beat to the retiring slot: the beat is illegal (count is already full). error is set and the clear still happens.
- Beats whose tag upper bits differ from FIFO_NUMBER are ignored silently.
- Reset mid-operation: all in-flight state is discarded; late completions for stale tags then flag error. Software resets the FIFO only when it is quiescent.

Decomposition:
- Shared package constants: BEATS_PER_REQ=64, RR_ADDR_LSB=9, default NBITS_TAG_LOW=3, and the tag field split (upper bits = FIFO number, lower bits = tag_low).
- Natural sub-module: fpc_rc_count_table. It holds the 2**NBITS_TAG_LOW by 7-bit counters with an increment port and a clear port, plus the full-flag per slot.
- Pointer, ready and retire logic stay in the top module.

Test Plan:
- Single request: issue once, then send 64 beats with tag {FIFO_NUMBER,0} and index 0..63 -> done_valid pulses once with done_tag_low=0 two cycles after the last beat; outstanding goes 1 then 0; error=0.
- Out-of-order completion: issue tags 0,1,2 and fully complete 2, then 1, then 0 -> done pulses on three consecutive cycles with tags 0,1,2, all after tag 0's last beat.
- Full/wrap: MAX_OUTSTANDING=8; issue 8 -> issue_ready=0 and outstanding=8. Complete and retire tag 0 -> issue_ready=1 and issue_tag_low=0. Run 20 requests -> pointers wrap correctly with no error.
- Errors, each from reset, each leaving counts unaffected and setting error:
  - a beat with index 5 when count=3;
  - a 65th beat;
  - a beat to a tag that is not in flight;
  - issue while issue_ready=0.
- Foreign tag: beats with upper tag bits != FIFO_NUMBER -> ignored, no count change, error=0.
- Async reset asserted mid-request with 30 beats received -> outputs clear immediately without waiting for a clock edge; outstanding=0; issue_tag_low=0.
